// File: rtl/cnn_output_collector_pkg.sv
// Shared definitions for the cnn output collector: default geometry,
// a constant-foldable clog2, the packed pixel word and serializer states.
package cnn_output_collector_pkg;

  localparam int O_WIDTH_DEF          = 16;
  localparam int CHANNELS_OUT_DEF     = 5;
  localparam int PIXELS_PER_FRAME_DEF = 21;
  localparam int FIFO_DEPTH_DEF       = 8;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // One cnn output pixel: channel c lives in bits [c*O_WIDTH +: O_WIDTH].
  typedef logic [CHANNELS_OUT_DEF*O_WIDTH_DEF-1:0] pixel_word_t;

  // Serializer state: IDLE while the buffer is empty, SEND while a word is offered.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/cnn_output_collector_pixel_fifo.sv
// Whole-pixel buffer: synchronous FIFO with a registered occupancy count.
// The head entry is read straight out of registered storage so the
// serializer sees stable data while it walks the channels.
module cnn_pixel_fifo
  import cnn_output_collector_pkg::*;
#(
  parameter int WIDTH = CHANNELS_OUT_DEF * O_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   count_o
);

  localparam int AW  = clog2(DEPTH);
  localparam int CW  = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Storage is not reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/cnn_output_collector.sv
// Output collector for the cnn: buffers whole pixels, serialises them into
// per-channel words on a ready/valid stream, throttles the cnn through
// cnn_clk_en and pulses frame_done after the last word of each frame.
// Optional statistics outputs (stall_cycles, frames_done) are built when
// CNN_COLLECTOR_STATS_EN is defined.
module cnn_output_collector
  import cnn_output_collector_pkg::*;
#(
  parameter int CHANNELS_OUT     = CHANNELS_OUT_DEF,
  parameter int O_WIDTH          = O_WIDTH_DEF,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF,
  parameter int PIXELS_PER_FRAME = PIXELS_PER_FRAME_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  input  logic [CHANNELS_OUT*O_WIDTH-1:0]           in_data,
  output logic                                      cnn_clk_en,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [O_WIDTH-1:0]                        out_data,
  output logic [((clog2(CHANNELS_OUT) > 0) ? clog2(CHANNELS_OUT) : 1)-1:0] out_channel,
  output logic                                      out_last_chan,
  output logic                                      out_last_pixel,
  output logic                                      frame_done
`ifdef CNN_COLLECTOR_STATS_EN
  ,
  output logic [31:0]                               stall_cycles,
  output logic [15:0]                               frames_done
`endif
);

  localparam int CH_W  = (clog2(CHANNELS_OUT) > 0) ? clog2(CHANNELS_OUT) : 1;
  localparam int PIX_W = (clog2(PIXELS_PER_FRAME) > 0) ? clog2(PIXELS_PER_FRAME) : 1;
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam int PW    = CHANNELS_OUT * O_WIDTH;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [PW-1:0]    head_pixel;
  logic             push;
  logic             pop;
  logic             accept;
  logic             last_chan;
  logic             last_pixel;

  ser_state_e       state_q;
  ser_state_e       state_d;
  logic [CH_W-1:0]  chan_q;
  logic [CH_W-1:0]  chan_d;
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] pix_d;
  logic             frame_done_q;
  logic             frame_done_d;

  logic [O_WIDTH-1:0] lane [CHANNELS_OUT];

  cnn_pixel_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (in_data),
    .pop_i   (pop),
    .data_o  (head_pixel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Stall decision comes only from the registered count, never from out_ready.
  assign cnn_clk_en = !fifo_full;
  assign push       = in_valid && cnn_clk_en;
  assign out_valid  = !fifo_empty;
  assign accept     = (state_q == ST_SEND) && out_ready;
  assign last_chan  = (chan_q == CH_W'(CHANNELS_OUT - 1));
  assign last_pixel = (pix_q == PIX_W'(PIXELS_PER_FRAME - 1));
  assign pop        = accept && last_chan;

  // Split the head pixel into per-channel lanes.
  for (genvar gi = 0; gi < CHANNELS_OUT; gi++) begin : g_lane
    assign lane[gi] = head_pixel[gi*O_WIDTH +: O_WIDTH];
  end

  // Select the lane addressed by the channel counter.
  always_comb begin
    out_data = lane[0];
    for (int c = 0; c < CHANNELS_OUT; c++) begin
      if (chan_q == CH_W'(c)) begin
        out_data = lane[c];
      end
    end
  end

  assign out_channel    = chan_q;
  assign out_last_chan  = last_chan;
  assign out_last_pixel = last_pixel;
  assign frame_done     = frame_done_q;

  // Serializer next state plus channel, pixel and frame-done next values.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    pix_d        = pix_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pop && (fifo_count == CNT_W'(1)) && !push) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      chan_d = last_chan ? '0 : chan_q + CH_W'(1);
    end

    if (pop) begin
      pix_d        = last_pixel ? '0 : pix_q + PIX_W'(1);
      frame_done_d = last_pixel;
    end
  end

  // Serializer and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      pix_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      pix_q        <= pix_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef CNN_COLLECTOR_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] frames_done_q;

  // Saturating counters of cnn stall cycles and completed frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      frames_done_q  <= '0;
    end else begin
      if (in_valid && !cnn_clk_en && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (frame_done_q && (frames_done_q != '1)) begin
        frames_done_q <= frames_done_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign frames_done  = frames_done_q;
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_cnn_output_collector.sv
// Scoreboard bench for cnn_output_collector: the stimulus side pushes the
// expected channel words when a pixel is captured, a monitor pops and
// compares every accepted word, checks stall stability and frame_done.
module tb_cnn_output_collector;
  import cnn_output_collector_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  ch;
    logic        lc;
    logic        lp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  pixel_word_t in_data = '0;
  logic        out_ready = 1'b0;
  logic        cnn_clk_en;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_channel;
  logic        out_last_chan;
  logic        out_last_pixel;
  logic        frame_done;
`ifdef CNN_COLLECTOR_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] frames_done;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   captured = 0;
  int   pix_model = 0;
  int   stall_model = 0;
  int   frames_model = 0;
  int   fd_seen = 0;
  bit   rnd_done = 0;

  cnn_output_collector dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .cnn_clk_en     (cnn_clk_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_channel    (out_channel),
    .out_last_chan  (out_last_chan),
    .out_last_pixel (out_last_pixel),
    .frame_done     (frame_done)
`ifdef CNN_COLLECTOR_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .frames_done    (frames_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic pixel_word_t mk(input int p);
    pixel_word_t r;
    r = '0;
    for (int c = 0; c < 5; c++) begin
      r[c*16 +: 16] = 16'(p * 16 + c) ^ 16'h3C00;
    end
    return r;
  endfunction

  // Offer one pixel until captured; push its expected words on capture.
  task automatic offer(input pixel_word_t px);
    bit en;
    bit ok;
    int n;
    exp_t e;
    n  = 0;
    ok = 0;
    in_valid = 1'b1;
    in_data  = px;
    while (!ok && n < 300) begin
      @(negedge clk);
      en = cnn_clk_en;
      if (!en) stall_model++;
      @(posedge clk);
      if (en) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout actual=not_captured required=captured t=%0t", $time);
    end else begin
      captured++;
      for (int c = 0; c < 5; c++) begin
        e.d  = px[c*16 +: 16];
        e.ch = 3'(c);
        e.lc = (c == 4);
        e.lp = (pix_model == 20);
        exp_q.push_back(e);
      end
      pix_model = (pix_model == 20) ? 0 : pix_model + 1;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare accepted words, stall stability and frame_done timing.
  initial begin
    logic        fd_pending;
    logic        hold;
    logic [15:0] hd;
    logic [2:0]  hc;
    logic [1:0]  hq;
    exp_t        e;
    fd_pending = 0;
    hold = 0;
    hd = '0;
    hc = '0;
    hq = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fd_pending = 0;
        hold = 0;
        continue;
      end
      if (frame_done) fd_seen++;
      if (frame_done || fd_pending) chk("frame_done", frame_done, fd_pending);
      fd_pending = 0;
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hd);
        chk("hold_channel", out_channel, hc);
        chk("hold_qualifiers", {out_last_chan, out_last_pixel}, hq);
      end
      hold = out_valid && !out_ready;
      hd = out_data;
      hc = out_channel;
      hq = {out_last_chan, out_last_pixel};
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected actual=%h/ch%0d required=no_word t=%0t",
                   out_data, out_channel, $time);
        end else begin
          e = exp_q.pop_front();
          if ({out_data, out_channel, out_last_chan, out_last_pixel} !==
              {e.d, e.ch, e.lc, e.lp}) begin
            errors++;
            $display("FAIL word actual=%h ch%0d lc%0b lp%0b required=%h ch%0d lc%0b lp%0b t=%0t",
                     out_data, out_channel, out_last_chan, out_last_pixel,
                     e.d, e.ch, e.lc, e.lp, $time);
          end
          $display("word %h ch%0d lc%0b lp%0b", out_data, out_channel, out_last_chan, out_last_pixel);
          if (e.lc && e.lp) begin
            fd_pending = 1;
            frames_model++;
          end
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_clk_en", cnn_clk_en, 1);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_channel", out_channel, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Single pixel: one-cycle latency, five consecutive words
    @(negedge clk);
    chk("sp_idle_valid", out_valid, 0);
    @(posedge clk);
    #1;
    offer({16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk("sp_latency_valid", out_valid, 1);
      if (k == 4) chk("sp_last_word_valid", out_valid, 1);
      if (k == 5) chk("sp_empty_after", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Reset mid-frame: 7 pixels buffered, 2 words sent, then reset
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) offer(mk(i));
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    pix_model = 0;
    stall_model = 0;
    frames_model = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_clk_en", cnn_clk_en, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;

    // Full frame, back-to-back
    base = fd_seen;
    for (int i = 0; i < 21; i++) offer(mk(100 + i));
    drain();
    chk("ff_frame_done_count", fd_seen - base, 1);

    // Backpressure: 10 pixels offered with out_ready low
    out_ready = 1'b0;
    base = captured;
    fork
      begin
        for (int i = 0; i < 10; i++) offer(mk(150 + i));
      end
      begin
        n = 0;
        while ((captured - base) < 8 && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk("bp_clk_en_low_at_full", cnn_clk_en, 0);
        repeat (6) @(negedge clk);
        chk("bp_captured_while_full", captured - base, 8);
        chk("bp_clk_en_still_low", cnn_clk_en, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_all_captured", captured - base, 10);

    // Stall hold: random out_ready across 3 frames of pixels
    base = fd_seen;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 63; i++) offer(mk(300 + i));
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rnd_frame_done_count", fd_seen - base, 3);

`ifdef CNN_COLLECTOR_STATS_EN
    chk("stats_stall_cycles", stall_cycles, stall_model);
    chk("stats_frames_done", frames_done, frames_model);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
